// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NUM_REQ requesters.
// Results return in issue order, MUL_LAT cycles after the grant, tagged one-hot.
module mul_share_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   a_in,
  input  logic [NUM_REQ*WIDTH-1:0]   b_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       busy,
  output logic                       idle
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e            state_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [NUM_REQ-1:0] tag_q  [MUL_LAT];
  logic [WIDTH-1:0]  data_q [MUL_LAT];

  logic              issue;
  logic              done;
  logic [PW-1:0]     gnt_idx;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;
  logic [WIDTH-1:0]  prod;

  // Search upward from rr_ptr with wrap; first requester found wins.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_b;
    gnt     = '0;
    gnt_idx = '0;
    issue   = 1'b0;
    idx     = 0;
    idx_b   = '0;
    if (state_q == StActive && en) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        idx   = (int'(rr_ptr_q) + i) % int'(NUM_REQ);
        idx_b = idx[PW-1:0];
        if (!issue && req[idx_b]) begin
          issue   = 1'b1;
          gnt_idx = idx_b;
        end
      end
      if (issue) gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    a_sel = a_in[gnt_idx*WIDTH +: WIDTH];
    b_sel = b_in[gnt_idx*WIDTH +: WIDTH];
    prod  = a_sel * b_sel;
  end

  assign done = |rsp_valid;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (issue) begin
        rr_ptr_q <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (issue && !done) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!issue && done) begin
        cnt_q <= cnt_q - CW'(1);
      end
      unique case (state_q)
        StIdle:   if (en) state_q <= StActive;
        StActive: if (!en) state_q <= (cnt_q != '0) ? StDrain : StIdle;
        StDrain: begin
          if (en) state_q <= StActive;
          else if (cnt_q == '0) state_q <= StIdle;
        end
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Tag doubles as the valid bit; data is zeroed alongside so rsp_data is 0 when idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      tag_q[0]  <= gnt;
      data_q[0] <= issue ? prod : '0;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        tag_q[i]  <= tag_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign rsp_valid = tag_q[MUL_LAT-1];
  assign rsp_data  = data_q[MUL_LAT-1];
  assign busy      = (cnt_q != '0);
  assign idle      = (state_q == StIdle);

endmodule

// File: tb/tb_mul_share_sched.sv
// Bench for mul_share_sched: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mul_share_sched;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic           idle;

  always #5 clk = ~clk;

  mul_share_sched #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(L)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .en        (en),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .idle      (idle)
  );

  typedef struct {int due; int tag; logic [W-1:0] val;} op_t;
  typedef struct {int cyc; logic [N-1:0] v; logic [W-1:0] d;} ev_t;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   bcnt = 0;
  bit   auto_drop = 1'b0;
  op_t  mq[$];
  ev_t  glog[$];
  ev_t  rlog[$];
  int   m_state = 0;  // 0 idle, 1 active, 2 drain
  int   m_ptr   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: grants from the rules, results from a due-time queue.
  always @(negedge clk) begin : cmp
    logic [N-1:0] eg, erv;
    logic [W-1:0] ed;
    logic [63:0]  pa, pb, p;
    int           gi, cnt, j;
    op_t          o;
    ev_t          e;
    if (!rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      mq.delete();
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_idle", 64'(idle), 64'(1));
    end else begin
      eg = '0;
      gi = -1;
      if (m_state == 1 && en && req != '0) begin
        for (int i = 0; i < N; i++) begin
          j = (m_ptr + i) % N;
          if (gi < 0 && req[j]) gi = j;
        end
        eg[gi] = 1'b1;
      end
      erv = '0;
      ed  = '0;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        erv[mq[0].tag] = 1'b1;
        ed = mq[0].val;
      end
      chk("gnt", 64'(gnt), 64'(eg));
      chk("rsp_valid", 64'(rsp_valid), 64'(erv));
      chk("rsp_data", 64'(rsp_data), 64'(ed));
      chk("busy", 64'(busy), 64'(mq.size() != 0));
      chk("idle", 64'(idle), 64'(m_state == 0));
      if (busy) bcnt++;
      if (gnt != '0) begin
        e.cyc = cyc; e.v = gnt; e.d = '0;
        glog.push_back(e);
      end
      if (rsp_valid != '0) begin
        e.cyc = cyc; e.v = rsp_valid; e.d = rsp_data;
        rlog.push_back(e);
      end
      cnt = mq.size();
      if (erv != '0) void'(mq.pop_front());
      if (gi >= 0) begin
        pa = 64'(a_in[gi*W +: W]);
        pb = 64'(b_in[gi*W +: W]);
        p  = pa * pb;
        o.due = cyc + L; o.tag = gi; o.val = p[W-1:0];
        mq.push_back(o);
        m_ptr = (gi + 1) % N;
      end
      case (m_state)
        0: if (en) m_state = 1;
        1: if (!en) m_state = (cnt != 0) ? 2 : 0;
        default: if (en) m_state = 1; else if (cnt == 0) m_state = 0;
      endcase
    end
    cyc++;
  end

  task automatic step();
    logic [N-1:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~g;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int start, k;
    start = glog.size();
    k = 0;
    while (glog.size() < start + n && k < budget) begin
      step();
      k++;
    end
    if (glog.size() < start + n) chk("grant_timeout", 64'(glog.size()), 64'(start + n));
  endtask

  task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[k*W +: W] = a;
    b_in[k*W +: W] = b;
  endtask

  function automatic ev_t gat(input int i);
    ev_t e;
    e.cyc = -1; e.v = '0; e.d = '0;
    if (i < glog.size()) e = glog[i];
    return e;
  endfunction

  function automatic ev_t rat(input int i);
    ev_t e;
    e.cyc = -1; e.v = '0; e.d = '0;
    if (i < rlog.size()) e = rlog[i];
    return e;
  endfunction

  initial begin : stim
    int g0, r0;
    logic [W-1:0] exp_d [4];
    rst_n = 1'b0; en = 1'b0; req = '0; a_in = '0; b_in = '0;
    steps(3);
    chk("lit_rst_idle", 64'(idle), 64'(1));
    chk("lit_rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    steps(2);

    // Single op 7*6
    en = 1'b1;
    step();
    g0 = glog.size(); r0 = rlog.size(); bcnt = 0;
    auto_drop = 1'b1;
    set_op(0, 32'd7, 32'd6);
    req = 4'b0001;
    wait_grants(1, 10);
    steps(8);
    chk("s1_gnt_count", 64'(glog.size() - g0), 64'(1));
    chk("s1_gnt", 64'(gat(g0).v), 64'(4'b0001));
    chk("s1_rsp_count", 64'(rlog.size() - r0), 64'(1));
    chk("s1_rsp_tag", 64'(rat(r0).v), 64'(4'b0001));
    chk("s1_rsp_data", 64'(rat(r0).d), 64'(42));
    chk("s1_rsp_lat", 64'(rat(r0).cyc - gat(g0).cyc), 64'(5));
    chk("s1_busy_cycles", 64'(bcnt), 64'(5));

    // Product wrap; pointer at 1
    r0 = rlog.size();
    set_op(1, 32'h0001_0000, 32'h0001_0000);
    set_op(2, 32'hFFFF_FFFF, 32'd2);
    req = 4'b0110;
    wait_grants(2, 10);
    steps(8);
    chk("s3_tag0", 64'(rat(r0).v), 64'(4'b0010));
    chk("s3_data0", 64'(rat(r0).d), 64'(0));
    chk("s3_tag1", 64'(rat(r0 + 1).v), 64'(4'b0100));
    chk("s3_data1", 64'(rat(r0 + 1).d), 64'(32'hFFFF_FFFE));
    chk("s3_back2back", 64'(rat(r0 + 1).cyc - rat(r0).cyc), 64'(1));

    // Drain with 3 in flight; pointer at 3 -> grants 3,0,1
    r0 = rlog.size();
    set_op(3, 32'd11, 32'd13);
    set_op(0, 32'd100, 32'd200);
    set_op(1, 32'h1234_5678, 32'h10);
    req = 4'b1011;
    wait_grants(3, 10);
    en = 1'b0;
    req = 4'b0100;
    step();
    chk("s4_drain_idle", 64'(idle), 64'(0));
    chk("s4_drain_busy", 64'(busy), 64'(1));
    chk("s4_drain_gnt", 64'(gnt), 64'(0));
    steps(8);
    chk("s4_rsp_count", 64'(rlog.size() - r0), 64'(3));
    chk("s4_tag0", 64'(rat(r0).v), 64'(4'b1000));
    chk("s4_data0", 64'(rat(r0).d), 64'(143));
    chk("s4_tag1", 64'(rat(r0 + 1).v), 64'(4'b0001));
    chk("s4_data1", 64'(rat(r0 + 1).d), 64'(20000));
    chk("s4_tag2", 64'(rat(r0 + 2).v), 64'(4'b0010));
    chk("s4_data2", 64'(rat(r0 + 2).d), 64'(32'h2345_6780));
    chk("s4_end_idle", 64'(idle), 64'(1));
    chk("s4_end_busy", 64'(busy), 64'(0));
    req = '0;

    // Reset with 2 in flight; pointer at 2 -> grants 2,3
    set_op(2, 32'd3, 32'd4);
    set_op(3, 32'd5, 32'd6);
    en = 1'b1;
    req = 4'b1100;
    wait_grants(2, 10);
    req = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_gnt", 64'(gnt), 64'(0));
    chk("s5_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("s5_rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("s5_rst_busy", 64'(busy), 64'(0));
    chk("s5_rst_idle", 64'(idle), 64'(1));
    steps(2);
    g0 = glog.size(); r0 = rlog.size();
    set_op(0, 32'd3, 32'd5);
    set_op(1, 32'd1000, 32'd1000);
    set_op(2, 32'h0000_FFFF, 32'h0000_FFFF);
    set_op(3, 32'd9, 32'd9);
    exp_d[0] = 32'd15; exp_d[1] = 32'd1000000; exp_d[2] = 32'hFFFE_0001; exp_d[3] = 32'd81;
    rst_n = 1'b1;
    wait_grants(4, 12);
    steps(8);
    chk("s5_rsp_count", 64'(rlog.size() - r0), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s5_gnt%0d", i), 64'(gat(g0 + i).v), 64'(1 << i));
      chk($sformatf("s5_gnt_cyc%0d", i), 64'(gat(g0 + i).cyc - gat(g0).cyc), 64'(i));
      chk($sformatf("s5_tag%0d", i), 64'(rat(r0 + i).v), 64'(1 << i));
      chk($sformatf("s5_data%0d", i), 64'(rat(r0 + i).d), 64'(exp_d[i]));
      chk($sformatf("s5_lat%0d", i), 64'(rat(r0 + i).cyc - gat(g0 + i).cyc), 64'(5));
    end

    // Fairness: 0101 held for 8 grants
    auto_drop = 1'b0;
    g0 = glog.size();
    req = 4'b0101;
    wait_grants(8, 20);
    req = '0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s6_gnt%0d", i), 64'(gat(g0 + i).v), 64'((i % 2 == 1) ? 4'b0100 : 4'b0001));
    end
    en = 1'b0;
    steps(10);
    chk("s6_end_idle", 64'(idle), 64'(1));
    chk("s6_end_busy", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mul_share_sched.md
MUL_SHARE_SCHED -- requirements
Module: mul_share_sched

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 4: number of requesters sharing one multiplier (2..8).
REQ-002 The block SHALL take parameter WIDTH, default 32: operand and result width in bits.
REQ-003 The block SHALL take parameter MUL_LAT, default 5: multiplier pipeline depth in cycles (>=1).
REQ-004 The block SHALL have port sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port en  input  1  scheduler enable; 0 blocks new grants.
REQ-007 The block SHALL have port req  input  NUM_REQ  per-requester multiply request, held until granted.
REQ-008 The block SHALL have port a_in  input  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i.
REQ-009 The block SHALL have port b_in  input  NUM_REQ*WIDTH  packed operand B; slice i belongs to requester i.
REQ-010 The block SHALL have port gnt  output  NUM_REQ  one-hot grant; the operands issue on the clock edge where gnt[i] is high.
REQ-011 The block SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle result strobe to the issuing requester.
REQ-012 The block SHALL have port rsp_data  output  WIDTH  shared result bus, valid only while rsp_valid is nonzero.
REQ-013 The block SHALL have port busy  output  1  high while any multiply is in flight.
REQ-014 The block SHALL have port idle  output  1  high when the state is IDLE.

Function
REQ-015 gnt SHALL be combinational from req, the round-robin pointer, state and en, and SHALL have at most one bit set.
REQ-016 gnt SHALL be nonzero only when state is ACTIVE, en=1 and req is nonzero.
REQ-017 The grant SHALL go to the first requester with req high, searching upward from pointer rr_ptr with wrap at NUM_REQ-1 -> 0.
REQ-018 On an issue edge to index k, rr_ptr SHALL become (k+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-019 Issue SHALL capture a_in/b_in slice k and tag k into pipeline stage 1; at most one issue per cycle.
REQ-020 rsp_valid[k] SHALL assert exactly MUL_LAT cycles after the issue edge, for one cycle, with rsp_data = (A*B) mod 2^WIDTH, unsigned.
REQ-021 Back-to-back issues SHALL be accepted every cycle; results SHALL return in issue order with no bubbles added.
REQ-022 An in-flight counter (0..MUL_LAT) SHALL count +1 per issue and -1 per rsp_valid; both in one cycle SHALL leave it unchanged; busy = (counter != 0).
REQ-023 The states SHALL be IDLE, ACTIVE and DRAIN.
REQ-024 IDLE->ACTIVE SHALL occur when en=1.
REQ-025 ACTIVE->DRAIN SHALL occur when en=0 and counter!=0.
REQ-026 ACTIVE->IDLE SHALL occur when en=0 and counter=0.
REQ-027 DRAIN->IDLE SHALL occur when the counter reaches 0 with en=0.
REQ-028 DRAIN->ACTIVE SHALL occur when en=1; grants SHALL resume the following cycle.
REQ-029 In-flight results SHALL always complete while en=0; disabling SHALL NOT drop or corrupt a result.
REQ-030 A request dropped before its grant edge SHALL issue nothing; req changing while gnt is high has no effect beyond that cycle.
REQ-031 rsp_data SHALL be driven 0 in cycles where rsp_valid = 0.

Reset
REQ-032 While sys_rst_n=0: state=IDLE, rr_ptr=0, counter=0, all pipeline valid bits and tags cleared, gnt=0, rsp_valid=0, rsp_data=0, busy=0, idle=1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight results; no rsp_valid SHALL appear for operations issued before reset.
REQ-034 After release, the first grant SHALL occur no earlier than the cycle after en is seen high in IDLE.

Verification
REQ-035 The bench SHALL cover: single op, en=1, req=0001, A=7, B=6 -> gnt=0001 one cycle; rsp_valid=0001, rsp_data=42 exactly 5 cycles later; busy high for 5 cycles.
REQ-036 The bench SHALL cover: all four req held, each issuing one op -> grant order 0,1,2,3 on consecutive cycles; results on consecutive cycles in the same order with the matching tags.
REQ-037 The bench SHALL cover: wrap, A=B=0x10000 -> rsp_data=0; A=0xFFFFFFFF, B=2 -> rsp_data=0xFFFFFFFE.
REQ-038 The bench SHALL cover: en dropped with 3 ops in flight -> state DRAIN, gnt=0, all 3 results delivered, then idle=1, busy=0.
REQ-039 The bench SHALL cover: sys_rst_n pulsed low with 2 ops in flight -> outputs at reset values immediately; no rsp_valid afterward; rr_ptr=0, so req=1111 grants requester 0 first.
REQ-040 The bench SHALL cover: rr fairness, req=0101 held for 8 grants -> alternating 0,2,0,2; requester 1 never granted.
